// File: rtl/ks_pkg.sv
// Shared definitions for the keystream context scheduler: FSM state codes,
// the saved-context payload, seed constants and the engine step math.
package ks_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;
  } ks_ctx_t;

  localparam ks_ctx_t CTX_RESET = '{s1: 8'h01, s2: 8'h02, s3: 8'h03};

  localparam logic [7:0] SEED_ZERO = 8'h00;
  localparam logic [7:0] SEED_ONES = 8'hFF;
  localparam logic [7:0] SEED_XOR  = 8'hA5;

  // Spread one seed byte across the three registers.
  function automatic ks_ctx_t seed_expand(input logic [7:0] seed);
    ks_ctx_t c;
    c.s1 = seed;
    c.s2 = {~seed[3:0], seed[7:4]};
    c.s3 = seed ^ SEED_XOR;
    return c;
  endfunction

  // Keystream bit produced by the current engine state.
  function automatic logic ks_bit(input ks_ctx_t c);
    return c.s1[0] ^ c.s2[0] ^ c.s3[0];
  endfunction

  // One engine step: each register shifts left with a cross-coupled feedback bit.
  function automatic ks_ctx_t ks_step(input ks_ctx_t c);
    ks_ctx_t n;
    n.s1 = {c.s1[6:0], c.s2[0] ^ c.s3[1]};
    n.s2 = {c.s2[6:0], c.s3[3] ^ c.s1[1]};
    n.s3 = {c.s3[6:0], c.s1[5] ^ c.s2[2]};
    return n;
  endfunction

endpackage

// File: rtl/ks_step_core.sv
// Shared keystream stepping engine.
// Ports: load/ld_ctx replace the working state and clear the keystream shift
// register; step advances one step and shifts the produced bit in MSB-first.
// nxt_c is the state after one step from the current state; ks_byte_c is the
// keystream byte including the bit of the step in progress.
module ks_step_core
  import ks_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  ks_ctx_t    ld_ctx,
  output ks_ctx_t    nxt_c,
  output logic [7:0] ks_byte_c
);

  ks_ctx_t    st_q, st_d;
  logic [6:0] sr_q, sr_d;
  logic       bit_c;

  // Next-state and keystream assembly.
  always_comb begin
    bit_c     = ks_bit(st_q);
    nxt_c     = ks_step(st_q);
    st_d      = st_q;
    sr_d      = sr_q;
    ks_byte_c = {sr_q, bit_c};
    if (load) begin
      st_d = ld_ctx;
      sr_d = '0;
    end else if (step) begin
      st_d = nxt_c;
      sr_d = {sr_q[5:0], bit_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= CTX_RESET;
      sr_q <= '0;
    end else begin
      st_q <= st_d;
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/ks_ctx_scheduler.sv
// Time-shares one keystream engine between NCH requester channels, each with
// a saved context. Round-robin grant, 8 steps per byte, XOR with the request
// byte, context write-back on DONE entry, result held until out_ready.
// Ports: req_valid/req_data/req_ready per-channel request side (req_ready is a
// combinational one-hot accept); cfg_we/cfg_ch/cfg_seed seed writes;
// out_valid/out_data/out_ch/out_ready result side; busy = not idle.
// Optional: define KS_WARMUP_EN to run WARMUP_STEPS discarded steps on the
// first grant after each seed load.
module ks_ctx_scheduler
  import ks_pkg::*;
#(
  parameter int unsigned  NCH          = 2,
  parameter int unsigned  WARMUP_STEPS = 16,
  localparam int unsigned CHW          = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req_valid,
  input  logic [8*NCH-1:0] req_data,
  output logic [NCH-1:0]   req_ready,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [7:0]       cfg_seed,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [CHW-1:0]   out_ch,
  input  logic             out_ready,
  output logic             busy
);

  logic [1:0]     state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [CHW-1:0] last_q, last_d, gnt_q, gnt_d;
  logic [7:0]     byte_q, byte_d;
  ks_ctx_t        ctx_q [NCH];
  ks_ctx_t        ctx_d [NCH];
  logic [NCH-1:0] seeded_q, seeded_d;
  logic           kill_q, kill_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_data_q, out_data_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;
  logic           busy_q, busy_d;

  logic [NCH-1:0] elig_c;
  logic           found_c;
  logic [CHW-1:0] gsel_c, cand_c;
  logic           seed_ok_c;
  logic           core_load_c, core_step_c;
  ks_ctx_t        core_nxt_c;
  logic [7:0]     ks_byte_c;

`ifdef KS_WARMUP_EN
  localparam int unsigned WCW = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [NCH-1:0] warm_q, warm_d;
`else
  logic unused_warm;
  assign unused_warm = (WARMUP_STEPS != 0);
`endif

  ks_step_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (core_load_c),
    .step      (core_step_c),
    .ld_ctx    (ctx_q[gsel_c]),
    .nxt_c     (core_nxt_c),
    .ks_byte_c (ks_byte_c)
  );

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    elig_c  = req_valid & seeded_q;
    found_c = 1'b0;
    gsel_c  = '0;
    cand_c  = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand_c = CHW'((32'(last_q) + k) % NCH);
      if (!found_c && elig_c[cand_c]) begin
        found_c = 1'b1;
        gsel_c  = cand_c;
      end
    end
  end

  assign seed_ok_c = cfg_we && (cfg_seed != SEED_ZERO) && (cfg_seed != SEED_ONES)
                     && (32'(cfg_ch) < NCH);

  // FSM next state, context bookkeeping and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    byte_d      = byte_q;
    ctx_d       = ctx_q;
    seeded_d    = seeded_q;
    kill_d      = kill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    req_ready   = '0;
    core_load_c = 1'b0;
    core_step_c = 1'b0;
`ifdef KS_WARMUP_EN
    wcnt_d      = wcnt_q;
    warm_d      = warm_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          req_ready[gsel_c] = 1'b1;
          core_load_c       = 1'b1;
          last_d            = gsel_c;
          gnt_d             = gsel_c;
          kill_d            = 1'b0;
          cnt_d             = '0;
          for (int unsigned i = 0; i < NCH; i++) begin
            if (gsel_c == CHW'(i)) byte_d = req_data[i*8 +: 8];
          end
`ifdef KS_WARMUP_EN
          wcnt_d  = '0;
          state_d = warm_q[gsel_c] ? ST_WARM : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef KS_WARMUP_EN
      ST_WARM: begin
        core_step_c = 1'b1;
        wcnt_d      = wcnt_q + WCW'(1);
        if (wcnt_q == WCW'(WARMUP_STEPS - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          wcnt_d  = '0;
          // A reseed during warm-up owns the flag; keep it for the next grant.
          if (!kill_q) warm_d[gnt_q] = 1'b0;
        end
      end
`endif
      ST_RUN: begin
        core_step_c = 1'b1;
        cnt_d       = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_data_d  = byte_q ^ ks_byte_c;
          out_ch_d    = gnt_q;
          if (!kill_q) ctx_d[gnt_q] = core_nxt_c;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_ch_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Seed writes apply in any state and take priority over write-back.
    if (seed_ok_c) begin
      ctx_d[cfg_ch]    = seed_expand(cfg_seed);
      seeded_d[cfg_ch] = 1'b1;
`ifdef KS_WARMUP_EN
      warm_d[cfg_ch]   = 1'b1;
`endif
      if ((cfg_ch == gnt_d) && (state_d != ST_IDLE)) kill_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= CHW'(NCH - 1);
      gnt_q       <= '0;
      byte_q      <= '0;
      for (int unsigned i = 0; i < NCH; i++) ctx_q[i] <= CTX_RESET;
      seeded_q    <= '0;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      busy_q      <= 1'b0;
`ifdef KS_WARMUP_EN
      wcnt_q      <= '0;
      warm_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      byte_q      <= byte_d;
      ctx_q       <= ctx_d;
      seeded_q    <= seeded_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      busy_q      <= busy_d;
`ifdef KS_WARMUP_EN
      wcnt_q      <= wcnt_d;
      warm_q      <= warm_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ks_ctx_scheduler.sv
// Self-checking bench for ks_ctx_scheduler (default build, NCH=2).
module tb_ks_ctx_scheduler;

  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [7:0]  cfg_seed;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [0:0]  out_ch;
  logic        out_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ks_ctx_scheduler #(.NCH(NCH), .WARMUP_STEPS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_seed  (cfg_seed),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // ---------------- reference model (transaction level) ----------------
  int m_s1 [NCH];
  int m_s2 [NCH];
  int m_s3 [NCH];
  bit m_seeded [NCH];
  int m_last;

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_s1[c] = 1; m_s2[c] = 2; m_s3[c] = 3; m_seeded[c] = 0;
    end
    m_last = NCH - 1;
  endfunction

  function automatic void m_seed(input int ch, input int v);
    if (v != 0 && v != 255) begin
      m_s1[ch] = v;
      m_s2[ch] = (((~v) & 15) << 4) | (v >> 4);
      m_s3[ch] = v ^ 'hA5;
      m_seeded[ch] = 1;
    end
  endfunction

  // Runs eight steps on a channel's saved context and returns the keystream byte.
  function automatic logic [7:0] m_byte(input int ch);
    int a, b, c, fa, fb, fc;
    logic [7:0] r;
    a = m_s1[ch]; b = m_s2[ch]; c = m_s3[ch];
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      r[7-k] = ((a ^ b ^ c) & 1) != 0;
      fa = (b ^ (c >> 1)) & 1;
      fb = ((c >> 3) ^ (a >> 1)) & 1;
      fc = ((a >> 5) ^ (b >> 2)) & 1;
      a = ((a << 1) | fa) & 255;
      b = ((b << 1) | fb) & 255;
      c = ((c << 1) | fc) & 255;
    end
    m_s1[ch] = a; m_s2[ch] = b; m_s3[ch] = c;
    return r;
  endfunction

  function automatic int m_pick(input logic [1:0] mask);
    int c;
    for (int k = 1; k <= NCH; k++) begin
      c = (m_last + k) % NCH;
      if (mask[c] && m_seeded[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_seed(input int ch, input logic [7:0] v);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_seed = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_seed(ch, int'(v));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  // Full request transaction; optionally holds out_ready low and/or
  // reseeds the granted channel a given number of edges after acceptance.
  task automatic request(input string nm, input logic [1:0] mask, input logic [15:0] data,
                         input int exp_ch, input logic [7:0] exp_data, input int hold,
                         input int seed_at, input logic [7:0] seed_val);
    int waited, lat;
    req_valid = mask; req_data = data;
    waited = 0;
    #1;
    while (req_ready == 2'b00 && waited < 4) begin
      @(posedge clk); #1; waited++;
    end
    if (req_ready == 2'b00) begin
      chk({nm, " grant_timeout"}, 32'(req_ready), 32'(1 << exp_ch));
      req_valid = '0;
      return;
    end
    chk({nm, " grant"}, 32'(req_ready), 32'(1 << exp_ch));
    @(posedge clk); #1;
    req_valid = '0;
    req_data  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++; #1;
      if (lat == seed_at) begin
        cfg_we = 1'b1; cfg_ch = 1'(exp_ch); cfg_seed = seed_val;
      end else begin
        cfg_we = 1'b0;
      end
    end
    cfg_we = 1'b0;
    chk({nm, " latency"}, 32'(lat), 32'd8);
    chk({nm, " out_data"}, 32'(out_data), 32'(exp_data));
    chk({nm, " out_ch"}, 32'(out_ch), 32'(exp_ch));
    for (int h = 0; h < hold; h++) begin
      req_valid = 2'b11;
      @(posedge clk); #1;
      chk({nm, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " hold_data"}, 32'(out_data), 32'(exp_data));
      chk({nm, " hold_ch"}, 32'(out_ch), 32'(exp_ch));
      chk({nm, " hold_no_grant"}, 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    if (hold > 0) chk({nm, " exit_no_grant"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    req_valid = '0;
    chk({nm, " idle_after"}, 32'({out_valid, busy}), 32'd0);
  endtask

  typedef struct {
    logic [7:0] seed;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int cnt, ch, r;
    logic [1:0] mask;
    logic [15:0] data;
    logic [7:0] exp, v;

    tbl[0] = '{seed: 8'h01, din: 8'h00, dout: 8'h82};
    tbl[1] = '{seed: 8'h01, din: 8'hFF, dout: 8'h7D};
    tbl[2] = '{seed: 8'h01, din: 8'h82, dout: 8'h00};

    rst_n = 1'b0; req_valid = '0; req_data = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_seed = '0; out_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    chk("reset_outputs", 32'({out_valid, out_data, out_ch, busy}), 32'd0);
    chk("reset_no_grant", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Table: seed ch0, one byte each
    for (int i = 0; i < 3; i++) begin
      do_seed(0, tbl[i].seed);
      void'(m_byte(0));
      m_last = 0;
      request($sformatf("vec%0d", i), 2'b01, {8'h00, tbl[i].din}, 0, tbl[i].dout, 0, -1, 8'h00);
      if (i == 0) chk("ctx0_writeback", 32'(dut.ctx_q[0]), 32'h010004);
    end

    // Round-robin with both channels requesting
    do_reset();
    do_seed(0, 8'h01);
    do_seed(1, 8'h01);
    for (int i = 0; i < 4; i++) begin
      data = 16'($urandom) & ((i < 2) ? 16'h0000 : 16'hFFFF);
      ch = m_pick(2'b11);
      chk($sformatf("rr_order%0d", i), 32'(ch), 32'(i % 2));
      m_last = ch;
      exp = 8'(data >> (8 * ch)) ^ m_byte(ch);
      if (i < 2) chk($sformatf("rr_first%0d", i), 32'(exp), 32'h82);
      request($sformatf("rr%0d", i), 2'b11, data, i % 2, exp, 0, -1, 8'h00);
    end

    // Invalid seeds never enable a channel
    do_reset();
    do_seed(1, 8'h00);
    do_seed(1, 8'hFF);
    req_valid = 2'b10;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      #1; if (req_ready[1] || busy) cnt++;
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("unseeded_no_grant", 32'(cnt), 32'd0);

    // Backpressure: result held for 20 cycles, no new grant
    do_seed(0, 8'h01);
    do_seed(1, 8'h01);
    m_last = 0;
    exp = m_byte(0);
    request("hold", 2'b01, 16'h0000, 0, 8'h82, 20, -1, 8'h00);

    // Reseed collision: in-flight byte uses old keystream; reseed wins the context
    do_seed(0, 8'h01);
    exp = m_byte(0);
    request("coll_a", 2'b01, 16'h0000, 0, 8'h82, 0, 3, 8'h01);
    m_seed(0, 1);
    exp = m_byte(0);
    request("coll_b", 2'b01, 16'h0000, 0, 8'h82, 0, -1, 8'h00);

    // Reset during RUN
    do_seed(0, 8'h01);
    req_valid = 2'b01; req_data = 16'h0000;
    #1;
    chk("rst_run_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_run_outputs", 32'({out_valid, out_data, out_ch, busy}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    req_valid = 2'b01;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1; if (req_ready != 2'b00 || busy) cnt++;
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("rst_unseeded_no_grant", 32'(cnt), 32'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 5));
        v = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
        do_seed(int'($urandom_range(0, 1)), v);
      end
      mask = 2'($urandom_range(0, 3));
      data = 16'($urandom);
      ch = m_pick(mask);
      if (ch < 0) begin
        req_valid = mask;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
          #1; if (req_ready != 2'b00) cnt++;
          @(posedge clk); #1;
        end
        req_valid = '0;
        chk($sformatf("rnd%0d_no_grant", it), 32'(cnt), 32'd0);
      end else begin
        m_last = ch;
        exp = 8'(data >> (8 * ch)) ^ m_byte(ch);
        request($sformatf("rnd%0d", it), mask, data, ch, exp,
                int'($urandom_range(0, 2)), -1, 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
